// File: rtl/prbs31_checker.sv
// -----------------------------------------------------------------------------
// prbs31_checker
//
// Serial PRBS31 (x^31 + x^28 + 1) receiver/checker. It self-seeds a local
// 31-bit LFSR from the received stream (HUNT), and once LOCK_COUNT
// consecutive predictions have matched it free-runs that LFSR in step with the
// stream (LOCKED). In LOCKED it counts checked bits and bit errors. It drops
// back to HUNT when UNLOCK_ERRS errors fall inside one WINDOW of valid bits.
//
// Ports
//   clk        in   1      clock
//   rst_n      in   1      synchronous active-low reset
//   rx_bit     in   1      received serial PRBS bit
//   rx_valid   in   1      rx_bit is valid this cycle; nothing moves when low
//   clr_cnt    in   1      synchronous clear of err_count / bit_count
//   locked     out  1      checker is in the LOCKED state
//   err_pulse  out  1      one-cycle pulse per detected bit error
//   err_count  out  ERR_W  errors since reset/clear, saturating
//   bit_count  out  CNT_W  bits checked while locked, saturating
// -----------------------------------------------------------------------------
module prbs31_checker #(
    parameter int LOCK_COUNT  = 64,
    parameter int WINDOW      = 128,
    parameter int UNLOCK_ERRS = 8,
    parameter int ERR_W       = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_bit,
    input  logic             rx_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);
    localparam int FILL_W  = 5;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q;
    logic [30:0]        sr_q;          // sr_q[30] is the oldest bit
    logic [FILL_W-1:0]  fill_q;        // bits shifted in since entering HUNT
    logic [MATCH_W-1:0] match_cnt_q;   // consecutive good predictions in HUNT
    logic [WIN_W-1:0]   win_cnt_q;     // position inside the error-rate window
    logic [WERR_W-1:0]  win_err_q;     // errors inside the current window
    logic               locked_q;
    logic               err_pulse_q;
    logic [ERR_W-1:0]   err_count_q;
    logic [CNT_W-1:0]   bit_count_q;

    // -------------------------------------------------------------------------
    // Prediction and window bookkeeping for the current valid bit
    // -------------------------------------------------------------------------
    logic               pred;
    logic               mis;
    logic               sr_full;
    logic               good_match;
    logic [MATCH_W-1:0] match_inc;
    logic               lock_hit;
    logic               win_wrap;
    logic [WERR_W-1:0]  win_err_sum;
    logic               unlock;
    logic               err_sat;
    logic               bit_sat;

    always_comb begin
        pred       = sr_q[27] ^ sr_q[30];
        mis        = rx_bit ^ pred;
        sr_full    = (fill_q == 5'd31);
        // An all-zero history predicts zero forever, so it must never count
        // towards lock even though every prediction "matches".
        good_match = sr_full && !mis && (sr_q != 31'd0);
        match_inc  = match_cnt_q + MATCH_W'(1);
        lock_hit   = (match_inc == MATCH_W'(LOCK_COUNT));
        // The bit that arrives while win_cnt sits at WINDOW-1 opens a new
        // window, so its error is the only one that window has seen so far.
        win_wrap   = (win_cnt_q == WIN_W'(WINDOW - 1));
        if (win_wrap) begin
            win_err_sum = WERR_W'(mis);
        end else begin
            win_err_sum = win_err_q + WERR_W'(mis);
        end
        unlock     = (win_err_sum >= WERR_W'(UNLOCK_ERRS));
        err_sat    = &err_count_q;
        bit_sat    = &bit_count_q;
    end

    // -------------------------------------------------------------------------
    // HUNT / LOCKED state machine with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            sr_q        <= '0;
            fill_q      <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;

            if (rx_valid) begin
                case (state_q)
                    ST_HUNT: begin
                        // Seed the local LFSR straight from the line.
                        sr_q <= {sr_q[29:0], rx_bit};
                        if (!sr_full) begin
                            fill_q <= fill_q + FILL_W'(1);
                        end
                        if (sr_full) begin
                            if (good_match) begin
                                match_cnt_q <= match_inc;
                                if (lock_hit) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end else begin
                                match_cnt_q <= '0;
                            end
                        end
                    end

                    ST_LOCKED: begin
                        // Free-run on our own prediction so a single flipped
                        // line bit shows up as exactly one error.
                        sr_q        <= {sr_q[29:0], pred};
                        err_pulse_q <= mis;
                        if (!bit_sat) begin
                            bit_count_q <= bit_count_q + CNT_W'(1);
                        end
                        if (mis && !err_sat) begin
                            err_count_q <= err_count_q + ERR_W'(1);
                        end

                        if (unlock) begin
                            state_q     <= ST_HUNT;
                            locked_q    <= 1'b0;
                            fill_q      <= '0;
                            match_cnt_q <= '0;
                            win_cnt_q   <= '0;
                            win_err_q   <= '0;
                        end else begin
                            win_err_q <= win_err_sum;
                            if (win_wrap) begin
                                win_cnt_q <= '0;
                            end else begin
                                win_cnt_q <= win_cnt_q + WIN_W'(1);
                            end
                        end
                    end

                    default: begin
                        state_q  <= ST_HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end

            // A clear overrides any increment made on the same edge.
            if (clr_cnt) begin
                err_count_q <= '0;
                bit_count_q <= '0;
            end
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule
